ps2_dir_sequencer: RTL and testbench
====================================

Name: ps2_dir_sequencer

Overview:
- Sits between the PS2_Controller byte stream (received_data / received_data_en) and the game/movement logic.
- Parses PS/2 set-2 make/break sequences, including E0 and F0 prefixes, and tracks which of the four arrow keys are held.
- Keeps a "current direction" equal to the most-recently-pressed key that is still held.
- Issues one-deep move commands to the consumer on a valid/ready handshake, with timed auto-repeat while a key is held.

Parameters:
- UP_CODE, 8'h75, scancode for up; accepted with or without E0 prefix.
- DOWN_CODE, 8'h72, scancode for down.
- LEFT_CODE, 8'h6B, scancode for left.
- RIGHT_CODE, 8'h74, scancode for right.
- REPEAT_CYCLES, 12500000, auto-repeat period in clocks (250 ms at 50 MHz); legal range ≥2.
- PREFIX_TIMEOUT, 250000, clocks allowed between a prefix byte and its follow-up byte; legal range ≥2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from PS2_Controller.
- rx_data_en  in  1  one-cycle strobe; rx_data is valid when high.
- dir_out  out  3  current direction: 0 none, 1 up, 2 down, 3 left, 4 right.
- held_keys  out  4  held mask {right, left, down, up}.
- move_valid  out  1  move command pending.
- move_dir  out  3  direction of the pending command, same encoding as dir_out.
- move_ready  in  1  consumer accepts the command when move_valid and move_ready are both high.

Behaviour:
- Reset: async assert forces decode FSM to IDLE; dir_out=0, held_keys=0, move_valid=0, move_dir=0; all counters cleared. Release is synchronous to CLOCK_50.
- Decode FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions happen only on rx_data_en.
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a MAKE(byte) and stays in IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is a MAKE(byte) and goes to IDLE.
  - BRK and EXT_BRK: any byte is a BREAK(byte) and goes to IDLE. This includes E0 and F0, which then match no key.
- Prefix timeout:
  - A counter runs while the FSM is not IDLE and clears on every rx_data_en.
  - At PREFIX_TIMEOUT-1 the FSM returns to IDLE and the partial sequence is discarded, with no key effect.
- Non-arrow bytes are ignored after FSM bookkeeping.
- MAKE of an arrow key:
  - If its held bit is already set (keyboard typematic), nothing happens.
  - Otherwise: set the bit, set dir_out to that key, and raise a PRESS request.
- BREAK of an arrow key:
  - Clear its bit.
  - If that key is dir_out, dir_out becomes the highest-priority remaining held key (up > down > left > right), or 0 if none.
  - A BREAK of a non-held key has no effect.
- Latency: held_keys and dir_out update on the clock edge after the rx_data_en cycle that completes the sequence (registered, 1 cycle).
- Repeat counter:
  - Clears whenever dir_out changes or dir_out=0.
  - Otherwise it increments each cycle. At REPEAT_CYCLES-1 it raises a REPEAT request for dir_out and wraps to 0.
  - If a PRESS and a REPEAT tick occur in the same cycle, PRESS wins and the counter clears.
- Command slot (single entry):
  - A request loads the slot when it is empty or is being accepted that same cycle. move_valid is then high on the next cycle with move_dir = request direction.
  - Slot full and not accepted: a PRESS overwrites move_dir (latest press wins, move_valid stays high); a REPEAT is dropped.
  - After acceptance with no new request, move_valid falls the next cycle.
  - move_dir holds its value while valid except on a PRESS overwrite.
- When dir_out goes to 0, a pending command is not cancelled.
- Reset mid-sequence or mid-handshake abandons everything, including any pending command.

Test Plan (REPEAT_CYCLES=20, PREFIX_TIMEOUT=8, move_ready=1 unless stated):
- Send E0,75 → held_keys=0001 and dir_out=1 one cycle after the second strobe; one move_valid pulse with move_dir=1; while held, further pulses every 20 cycles.
- Press 75 then 6B, then send E0,F0,6B → dir_out goes 1, then 3, then back to 1; held_keys goes 0001, 0101, 0001. Send F0,75 → dir_out=0, held_keys=0, repeats stop.
- With move_ready=0: press 72 then 74 → move_valid stays 1 and move_dir=4 (overwrite). Hold 40 cycles → move_dir still 4 (repeats dropped). Raise move_ready → one accept, then a repeat command follows.
- Send E0, wait 8 cycles with no byte, send 75 → FSM times out first, so 75 is treated as a non-extended MAKE: dir_out=1. Send F0, wait 10 cycles, send 75 → no break, held_keys stays 0001.
- Send 75 twice (typematic) → a single move command, no change in repeat phase. Send 1C (non-arrow) → no output change.
- Assert reset asynchronously mid-sequence (after E0,F0) and with move_valid=1 → all outputs are 0 immediately. After release, 75 alone produces MAKE up.

Source files
------------

// File: rtl/ps2_dir_sequencer.sv
// ps2_dir_sequencer
// Decodes PS/2 set-2 make/break sequences (with E0/F0 prefixes) for the four
// arrow keys, tracks which are held, keeps the most recently pressed held key
// as the current direction, and offers move commands through a single-entry
// valid/ready slot with timed auto-repeat.
module ps2_dir_sequencer #(
  parameter logic [7:0] UP_CODE        = 8'h75,
  parameter logic [7:0] DOWN_CODE      = 8'h72,
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter int unsigned REPEAT_CYCLES  = 12500000,
  parameter int unsigned PREFIX_TIMEOUT = 250000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic [2:0] dir_out,
  output logic [3:0] held_keys,
  output logic       move_valid,
  output logic [2:0] move_dir,
  input  logic       move_ready
);

  // Decode FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic [7:0] EXT_BYTE = 8'hE0;
  localparam logic [7:0] BRK_BYTE = 8'hF0;

  // Direction encoding shared by dir_out and move_dir
  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam int PW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PREFIX_TIMEOUT - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [PW-1:0] pre_cnt_r;
  logic [RW-1:0] rep_cnt_r;
  logic [3:0]    held_r;
  logic [3:0]    held_nxt_s;
  logic [2:0]    dir_r;
  logic [2:0]    dir_nxt_s;
  logic          mv_valid_r;
  logic [2:0]    mv_dir_r;
  logic          make_s;
  logic          brk_s;
  logic [2:0]    key_dir_s;
  logic [3:0]    key_bit_s;
  logic          press_s;
  logic          rep_tick_s;
  logic          slot_free_s;

  // Map a scancode to a direction; anything else is DIR_NONE.
  function automatic logic [2:0] code_to_dir(input logic [7:0] code);
    logic [2:0] d;
    if (code == UP_CODE)         d = DIR_UP;
    else if (code == DOWN_CODE)  d = DIR_DOWN;
    else if (code == LEFT_CODE)  d = DIR_LEFT;
    else if (code == RIGHT_CODE) d = DIR_RIGHT;
    else                         d = DIR_NONE;
    return d;
  endfunction

  // One-hot held-mask bit for a direction: {right, left, down, up}.
  function automatic logic [3:0] dir_to_mask(input logic [2:0] d);
    logic [3:0] m;
    case (d)
      DIR_UP:    m = 4'b0001;
      DIR_DOWN:  m = 4'b0010;
      DIR_LEFT:  m = 4'b0100;
      DIR_RIGHT: m = 4'b1000;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  // Highest-priority held key: up > down > left > right.
  function automatic logic [2:0] pick_dir(input logic [3:0] m);
    logic [2:0] d;
    if (m[0])      d = DIR_UP;
    else if (m[1]) d = DIR_DOWN;
    else if (m[2]) d = DIR_LEFT;
    else if (m[3]) d = DIR_RIGHT;
    else           d = DIR_NONE;
    return d;
  endfunction

  assign key_dir_s = code_to_dir(rx_data);
  assign key_bit_s = dir_to_mask(key_dir_s);

  // Decode FSM next state and make/break event detection; a stale prefix drops back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    make_s      = 1'b0;
    brk_s       = 1'b0;
    if (rx_data_en) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == EXT_BYTE) begin
            state_nxt_s = ST_EXT;
          end else if (rx_data == BRK_BYTE) begin
            state_nxt_s = ST_BRK;
          end else begin
            make_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (rx_data == BRK_BYTE) begin
            state_nxt_s = ST_EXT_BRK;
          end else if (rx_data == EXT_BYTE) begin
            state_nxt_s = ST_EXT;
          end else begin
            make_s      = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          brk_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else if ((state_r != ST_IDLE) && (pre_cnt_r == PRE_LAST)) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Held-mask / direction update and PRESS request generation.
  always_comb begin
    held_nxt_s = held_r;
    dir_nxt_s  = dir_r;
    press_s    = 1'b0;
    if (make_s && (key_dir_s != DIR_NONE) && ((held_r & key_bit_s) == 4'b0000)) begin
      held_nxt_s = held_r | key_bit_s;
      dir_nxt_s  = key_dir_s;
      press_s    = 1'b1;
    end else if (brk_s && (key_dir_s != DIR_NONE) && ((held_r & key_bit_s) != 4'b0000)) begin
      held_nxt_s = held_r & ~key_bit_s;
      if (dir_r == key_dir_s) begin
        dir_nxt_s = pick_dir(held_r & ~key_bit_s);
      end else begin
        dir_nxt_s = dir_r;
      end
    end else begin
      held_nxt_s = held_r;
      dir_nxt_s  = dir_r;
    end
  end

  // A repeat fires only while the direction is steady and no press is competing.
  assign rep_tick_s  = (dir_r != DIR_NONE) && (dir_nxt_s == dir_r) && !press_s &&
                       (rep_cnt_r == REP_LAST);
  assign slot_free_s = !mv_valid_r || move_ready;

  // Decode FSM state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Prefix timeout counter: runs only while a prefix is outstanding.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pre_cnt_r <= '0;
    end else if (rx_data_en || (state_r == ST_IDLE) || (pre_cnt_r == PRE_LAST)) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PW'(1);
    end
  end

  // Held keys and current direction registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held_r <= 4'b0000;
      dir_r  <= DIR_NONE;
    end else begin
      held_r <= held_nxt_s;
      dir_r  <= dir_nxt_s;
    end
  end

  // Auto-repeat counter: restarts on any direction change or new press, wraps on each tick.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rep_cnt_r <= '0;
    end else if (press_s || (dir_nxt_s != dir_r) || (dir_nxt_s == DIR_NONE)) begin
      rep_cnt_r <= '0;
    end else if (rep_cnt_r == REP_LAST) begin
      rep_cnt_r <= '0;
    end else begin
      rep_cnt_r <= rep_cnt_r + RW'(1);
    end
  end

  // Single-entry command slot: presses always land (overwriting), repeats only into a free slot.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mv_valid_r <= 1'b0;
      mv_dir_r   <= DIR_NONE;
    end else if (press_s) begin
      mv_valid_r <= 1'b1;
      mv_dir_r   <= dir_nxt_s;
    end else if (rep_tick_s && slot_free_s) begin
      mv_valid_r <= 1'b1;
      mv_dir_r   <= dir_r;
    end else if (mv_valid_r && move_ready) begin
      mv_valid_r <= 1'b0;
      mv_dir_r   <= mv_dir_r;
    end else begin
      mv_valid_r <= mv_valid_r;
      mv_dir_r   <= mv_dir_r;
    end
  end

  assign dir_out    = dir_r;
  assign held_keys  = held_r;
  assign move_valid = mv_valid_r;
  assign move_dir   = mv_dir_r;

endmodule

// File: tb/tb_ps2_dir_sequencer.sv
// Testbench for ps2_dir_sequencer: table-driven byte vectors plus hand-written
// sequences for auto-repeat timing, backpressure, prefix timeout and reset.
module tb_ps2_dir_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_en;
  logic [2:0] dir_out;
  logic [3:0] held_keys;
  logic       move_valid;
  logic [2:0] move_dir;
  logic       move_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] dir;
    logic [3:0] held;
    logic       vld;
    logic [2:0] mdir;
  } vec_t;

  vec_t vecs [25];

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_dir_sequencer #(
    .REPEAT_CYCLES(20),
    .PREFIX_TIMEOUT(8)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_data_en(rx_data_en),
    .dir_out   (dir_out),
    .held_keys (held_keys),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .move_ready(move_ready)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int d, input int h, input int v, input int md);
    chk({nm, ".dir"}, dir_out, d);
    chk({nm, ".held"}, held_keys, h);
    chk({nm, ".valid"}, move_valid, v);
    chk({nm, ".mdir"}, move_dir, md);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    rx_data_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle strobe; on return the edge that consumed the byte has passed.
  task automatic send(input logic [7:0] b);
    rx_data    = b;
    rx_data_en = 1'b1;
    tick();
    rx_data_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Watchdog against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first;
    int npulse;
    int seen;

    vecs[0]  = '{8'hE0, 3'd0, 4'b0000, 1'b0, 3'd0};
    vecs[1]  = '{8'h75, 3'd1, 4'b0001, 1'b1, 3'd1};
    vecs[2]  = '{8'h6B, 3'd3, 4'b0101, 1'b1, 3'd3};
    vecs[3]  = '{8'hE0, 3'd3, 4'b0101, 1'b0, 3'd3};
    vecs[4]  = '{8'hF0, 3'd3, 4'b0101, 1'b0, 3'd3};
    vecs[5]  = '{8'h6B, 3'd1, 4'b0001, 1'b0, 3'd3};
    vecs[6]  = '{8'h72, 3'd2, 4'b0011, 1'b1, 3'd2};
    vecs[7]  = '{8'h1C, 3'd2, 4'b0011, 1'b0, 3'd2};
    vecs[8]  = '{8'h72, 3'd2, 4'b0011, 1'b0, 3'd2};
    vecs[9]  = '{8'hF0, 3'd2, 4'b0011, 1'b0, 3'd2};
    vecs[10] = '{8'h75, 3'd2, 4'b0010, 1'b0, 3'd2};
    vecs[11] = '{8'hF0, 3'd2, 4'b0010, 1'b0, 3'd2};
    vecs[12] = '{8'h72, 3'd0, 4'b0000, 1'b0, 3'd2};
    vecs[13] = '{8'hF0, 3'd0, 4'b0000, 1'b0, 3'd2};
    vecs[14] = '{8'h74, 3'd0, 4'b0000, 1'b0, 3'd2};
    vecs[15] = '{8'hE0, 3'd0, 4'b0000, 1'b0, 3'd2};
    vecs[16] = '{8'hE0, 3'd0, 4'b0000, 1'b0, 3'd2};
    vecs[17] = '{8'h74, 3'd4, 4'b1000, 1'b1, 3'd4};
    vecs[18] = '{8'hE0, 3'd4, 4'b1000, 1'b0, 3'd4};
    vecs[19] = '{8'hF0, 3'd4, 4'b1000, 1'b0, 3'd4};
    vecs[20] = '{8'hF0, 3'd4, 4'b1000, 1'b0, 3'd4};
    vecs[21] = '{8'h74, 3'd4, 4'b1000, 1'b0, 3'd4};
    vecs[22] = '{8'hE0, 3'd4, 4'b1000, 1'b0, 3'd4};
    vecs[23] = '{8'hF0, 3'd4, 4'b1000, 1'b0, 3'd4};
    vecs[24] = '{8'h74, 3'd0, 4'b0000, 1'b0, 3'd4};

    reset      = 1'b1;
    rx_data    = 8'h00;
    rx_data_en = 1'b0;
    move_ready = 1'b1;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Table: prefixes, priority fallback, typematic, non-arrow, stray breaks.
    for (int i = 0; i < 25; i++) begin
      send(vecs[i].data);
      chk_all($sformatf("vec%0d", i), vecs[i].dir, vecs[i].held, vecs[i].vld, vecs[i].mdir);
    end

    // Auto-repeat period while held, and no repeats after release.
    do_reset();
    send(8'hE0);
    send(8'h75);
    chk_all("rep_press", 1, 1, 1, 1);
    for (int w = 0; w < 2; w++) begin
      first  = 0;
      npulse = 0;
      for (int i = 1; i <= 20; i++) begin
        tick();
        if (move_valid) begin
          npulse++;
          if (first == 0) first = i;
        end
      end
      chk($sformatf("rep_first%0d", w), first, 20);
      chk($sformatf("rep_count%0d", w), npulse, 1);
      chk($sformatf("rep_mdir%0d", w), move_dir, 1);
    end
    send(8'hF0);
    send(8'h75);
    chk_all("rep_release", 0, 0, 0, 1);
    npulse = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (move_valid) npulse++;
    end
    chk("rep_after_release", npulse, 0);

    // Backpressure: press overwrite, repeats dropped, then accept and next repeat.
    do_reset();
    move_ready = 1'b0;
    send(8'h72);
    chk_all("bp_down", 2, 2, 1, 2);
    send(8'h74);
    chk_all("bp_right", 4, 10, 1, 4);
    idle(40);
    chk_all("bp_hold", 4, 10, 1, 4);
    move_ready = 1'b1;
    tick();
    chk("bp_accept_drop", move_valid, 0);
    seen = 0;
    for (int i = 0; i < 25 && seen == 0; i++) begin
      tick();
      if (move_valid) seen = i + 1;
    end
    chk("bp_repeat_after", seen, 19);
    chk("bp_repeat_dir", move_dir, 4);

    // Prefix timeout at both sides of the boundary.
    do_reset();
    send(8'hE0);
    idle(8);
    send(8'h75);
    chk("to_make_dir", dir_out, 1);
    chk("to_make_held", held_keys, 1);
    send(8'hF0);
    idle(8);
    send(8'h75);
    chk("to_brk_expired_held", held_keys, 1);
    chk("to_brk_expired_dir", dir_out, 1);
    send(8'hF0);
    idle(6);
    send(8'h75);
    chk("to_brk_live_held", held_keys, 0);
    chk("to_brk_live_dir", dir_out, 0);

    // Async reset mid-sequence with a pending command.
    do_reset();
    move_ready = 1'b0;
    send(8'h75);
    send(8'hE0);
    send(8'hF0);
    chk("ar_pre_valid", move_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("ar_immediate", 0, 0, 0, 0);
    tick();
    tick();
    reset      = 1'b0;
    move_ready = 1'b1;
    tick();
    send(8'h75);
    chk_all("ar_after", 1, 1, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
